// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_master
//  Description : Single-outstanding AXI4-Lite master. Turns one command into
//                one AXI read or write, with a base-address offset, a
//                per-transaction timeout and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h00000000,
  parameter int                            C_TIMEOUT_CYCLES   = 256
) (
  input  logic                              clk,
  input  logic                              resetn,
  // command port
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  // AXI-Lite write side
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AXI-Lite read side
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  // status
  output logic [15:0]                       err_count
);

  localparam int                  c_strb_w    = C_M_AXI_DATA_WIDTH / 8;
  localparam int                  c_timer_w   = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(C_TIMEOUT_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                          r_state;
  logic                            r_cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [c_strb_w-1:0]             r_wstrb;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_rsp_valid;
  logic                            r_rsp_write;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]                      r_rsp_resp;
  logic                            r_rsp_timeout;
  logic [c_timer_w-1:0]            r_timer;
  logic [15:0]                     r_err_count;

  logic                            w_accept;
  logic                            w_expired;
  logic                            w_aw_done;
  logic                            w_w_done;
  logic                            w_rsp_hs;
  logic                            w_rsp_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr;

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_expired = (r_timer >= c_timer_last);
  // A channel counts as done once its VALID has dropped or is handshaking now
  assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
  assign w_w_done  = ~r_wvalid  | M_AXI_WREADY;
  assign w_rsp_hs  = r_rsp_valid & rsp_ready;
  assign w_rsp_err = (r_rsp_resp != 2'b00) | r_rsp_timeout;
  assign w_addr    = cmd_addr + C_BASEADDR;

  // Transaction sequencer: command capture, AXI handshakes, timeout abort, response hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= w_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_rsp_write <= cmd_write;
            r_timer     <= '0;
            if (cmd_write) begin
              r_state   <= WR_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= RD_AR;
              r_arvalid <= 1'b1;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        WR_AW_W: begin
          r_timer <= r_timer + c_timer_one;
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= WR_B;
          end else if (w_expired) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_resp    <= 2'b10;
            r_rsp_rdata   <= '0;
            r_state       <= RSP;
          end else begin
            if (M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          end
        end
        WR_B: begin
          r_timer <= r_timer + c_timer_one;
          r_bready <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_state <= RSP;
          if (M_AXI_BVALID) begin
            r_rsp_resp    <= M_AXI_BRESP;
            r_rsp_timeout <= 1'b0;
          end else if (w_expired) begin
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_bready    <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_state     <= WR_B;
          end
        end
        RD_AR: begin
          r_timer <= r_timer + c_timer_one;
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_R;
          end else if (w_expired) begin
            r_arvalid     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_resp    <= 2'b10;
            r_rsp_rdata   <= '0;
            r_state       <= RSP;
          end
        end
        RD_R: begin
          r_timer <= r_timer + c_timer_one;
          if (M_AXI_RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= M_AXI_RDATA;
            r_rsp_resp    <= M_AXI_RRESP;
            r_rsp_timeout <= 1'b0;
            r_state       <= RSP;
          end else if (w_expired) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_resp    <= 2'b10;
            r_rsp_rdata   <= '0;
            r_state       <= RSP;
          end
        end
        RSP: begin
          // cmd_ready rises only after the response handshake, never with it
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating count of error or timed-out responses, counted at the response handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_count <= 16'h0000;
    end else if (w_rsp_hs && w_rsp_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_master
//  Description : Table-driven bench for axi_lite_master with a scripted slave
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

  localparam logic [31:0] c_BASE = 32'h10000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (32),
    .C_BASEADDR         (c_BASE),
    .C_TIMEOUT_CYCLES   (16)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .err_count     (err_count)
  );

  // One command plus slave behaviour plus the expected response
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;     // AWVALID cycles before AWREADY
    int          w_dly;      // WVALID cycles before WREADY
    int          b_dly;      // BREADY cycles before BVALID
    int          ar_dly;     // ARVALID cycles before ARREADY
    int          r_dly;      // RREADY cycles before RVALID
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;
    int          stall;      // cycles rsp_ready is held low
    int          exp_lat;    // cycle of first rsp_valid, acceptance = cycle 0
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b11;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = 32'hBAD0BAD0;
    M_AXI_RRESP   = 2'b11;
  endtask

  task automatic chk_rsp(input vec_t v);
    chk("rsp_valid",   rsp_valid,   1);
    chk("rsp_write",   rsp_write,   v.wr);
    chk("rsp_rdata",   rsp_rdata,   v.exp_rdata);
    chk("rsp_resp",    rsp_resp,    v.exp_resp);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    chk("cmd_ready_in_rsp", cmd_ready, 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int cyc = 1, waitc = 0;
    logic [31:0] ea;
    ea = v.addr + c_BASE;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    while (!cmd_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    while (!rsp_valid && cyc < 40) begin
      slave_idle();
      chk("cmd_ready_busy", cmd_ready, 0);
      if (v.wr) begin
        if (aw_hs > 0) chk("awvalid_drop", M_AXI_AWVALID, 0);
        if (w_hs > 0)  chk("wvalid_drop",  M_AXI_WVALID,  0);
        if (M_AXI_AWVALID) begin
          chk("awaddr", M_AXI_AWADDR, ea);
          if (aw_seen >= v.aw_dly) begin M_AXI_AWREADY = 1'b1; aw_hs++; end
          aw_seen++;
        end
        if (M_AXI_WVALID) begin
          chk("wdata", M_AXI_WDATA, v.wdata);
          chk("wstrb", {28'h0, M_AXI_WSTRB}, {28'h0, v.wstrb});
          if (w_seen >= v.w_dly) begin M_AXI_WREADY = 1'b1; w_hs++; end
          w_seen++;
        end
        if (M_AXI_BREADY) begin
          if (b_seen >= v.b_dly) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = v.slv_resp; b_hs++; end
          b_seen++;
        end
      end else begin
        if (ar_hs > 0) chk("arvalid_drop", M_AXI_ARVALID, 0);
        if (M_AXI_ARVALID) begin
          chk("araddr", M_AXI_ARADDR, ea);
          if (ar_seen >= v.ar_dly) begin M_AXI_ARREADY = 1'b1; ar_hs++; end
          ar_seen++;
        end
        if (M_AXI_RREADY) begin
          if (r_seen >= v.r_dly) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = v.slv_rdata;
            M_AXI_RRESP  = v.slv_resp;
            r_hs++;
          end
          r_seen++;
        end
      end
      tick();
      cyc++;
    end
    slave_idle();
    chk("rsp_latency", cyc, v.exp_lat);
    chk("axi_outputs_idle_in_rsp",
        {27'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    if (v.wr) begin
      chk("aw_handshakes", aw_hs, 1);
      chk("w_handshakes",  w_hs,  1);
      chk("b_handshakes",  b_hs,  v.exp_to ? 0 : 1);
    end else begin
      chk("ar_handshakes", ar_hs, 1);
      chk("r_handshakes",  r_hs,  v.exp_to ? 0 : 1);
    end
    for (int s = 0; s <= v.stall; s++) begin
      chk_rsp(v);
      if (s == v.stall) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
    if (v.exp_resp != 2'b00 || v.exp_to) exp_err++;
    chk("err_count", {16'h0, err_count}, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //              wr    addr          wdata         strb  aw w  b    ar r    slv_rdata     sresp  st lat exp_rdata     eresp  to
    vecs[0]  = '{1'b1, 32'h00000004, 32'hDEADBEEF, 4'hF, 0, 0, 0,   0, 0,   32'h00000000, 2'b00, 0, 3,  32'h00000000, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 32'h00000008, 32'h00000000, 4'h0, 0, 0, 0,   5, 0,   32'h12345678, 2'b00, 0, 8,  32'h12345678, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 32'h00000010, 32'h0BADF00D, 4'h3, 3, 0, 0,   0, 0,   32'h00000000, 2'b00, 0, 6,  32'h00000000, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 32'h00000014, 32'hCAFEBABE, 4'hC, 0, 3, 0,   0, 0,   32'h00000000, 2'b00, 0, 6,  32'h00000000, 2'b00, 1'b0};
    vecs[4]  = '{1'b1, 32'h00000020, 32'h11223344, 4'hF, 0, 0, 0,   0, 0,   32'h00000000, 2'b10, 4, 3,  32'h00000000, 2'b10, 1'b0};
    vecs[5]  = '{1'b0, 32'h00000030, 32'h00000000, 4'h0, 0, 0, 0,   0, 100, 32'hAAAA5555, 2'b00, 0, 17, 32'h00000000, 2'b10, 1'b1};
    vecs[6]  = '{1'b0, 32'h00000034, 32'h00000000, 4'h0, 0, 0, 0,   0, 14,  32'h5A5A5A5A, 2'b00, 0, 17, 32'h5A5A5A5A, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 32'h00000038, 32'h00000000, 4'h0, 0, 0, 0,   0, 15,  32'h5A5A5A5A, 2'b00, 0, 17, 32'h00000000, 2'b10, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000003C, 32'h76543210, 4'hF, 0, 0, 100, 0, 0,   32'h00000000, 2'b00, 0, 17, 32'h00000000, 2'b10, 1'b1};
    vecs[9]  = '{1'b0, 32'h00000040, 32'h00000000, 4'h0, 0, 0, 0,   1, 2,   32'hFFFF0000, 2'b11, 0, 6,  32'hFFFF0000, 2'b11, 1'b0};
    vecs[10] = '{1'b1, 32'hF0000004, 32'h000000A5, 4'h1, 0, 0, 0,   0, 0,   32'h00000000, 2'b00, 0, 3,  32'h00000000, 2'b00, 1'b0};
    vecs[11] = '{1'b1, 32'h00000044, 32'h00000000, 4'h0, 0, 0, 0,   0, 0,   32'h00000000, 2'b01, 2, 3,  32'h00000000, 2'b01, 1'b0};

    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    slave_idle();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_fields", {29'h0, rsp_valid, rsp_write, rsp_timeout}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_axi_valid_ready",
        {27'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("rst_addr", M_AXI_AWADDR, 0);
    chk("rst_wdata", M_AXI_WDATA, 0);
    chk("rst_err_count", {16'h0, err_count}, 0);
    resetn = 1'b1;
    tick();
    chk("cmd_ready_first_edge", cmd_ready, 1);

    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // Reset asserted while waiting in RD_R
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h00000050;
    tick();
    cmd_valid = 1'b0;
    chk("mid_arvalid", M_AXI_ARVALID, 1);
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    chk("mid_rready", M_AXI_RREADY, 1);
    tick();
    resetn = 1'b0;
    #1;
    chk("mid_rst_outputs",
        {24'h0, cmd_ready, rsp_valid, rsp_timeout,
         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("mid_rst_addr", M_AXI_ARADDR, 0);
    chk("mid_rst_err_count", {16'h0, err_count}, 0);
    repeat (3) begin
      tick();
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    resetn = 1'b1;
    exp_err = 0;
    tick();
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    run_cmd(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
